// File: rtl/clahe_excess_pkg.sv
// Shared types and helpers for the CLAHE excess-count store.
// State encoding for the clear sequencer, default geometry constants and a
// width-generic saturating adder (operands up to 32 bits).
package clahe_excess_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_DEPTH  = 32;
  localparam int DEF_NUM_RD = 4;

  // Adds two unsigned values and clips the result to 2^w - 1.
  // Bit 32 of the return value flags that clipping happened; bits [31:0]
  // carry the (possibly clipped) sum, which always fits in w bits.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input int unsigned w);
    logic [32:0] sum;
    logic [32:0] max_v;
    sum   = {1'b0, a} + {1'b0, b};
    max_v = (33'd1 << w) - 33'd1;
    if (sum > max_v) begin
      sat_add = {1'b1, max_v[31:0]};
    end else begin
      sat_add = {1'b0, sum[31:0]};
    end
  endfunction

endpackage

// File: rtl/excess_clear_seq.sv
// Clear sequencer for the excess-count store.
// Sweeps every entry once, writing zero, after reset and on each clr_start
// seen while idle. The sweep lasts exactly DEPTH cycles with busy high
// throughout; clr_start during a sweep is ignored.
//
// state    | meaning
// ---------+----------------------------------------------------------
// ST_IDLE  | store usable by the user write port, waiting for clr_start
// ST_CLEAR | zeroing mem[ptr] each cycle, user writes are dropped
module excess_clear_seq
  import clahe_excess_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_start,
  output logic              busy,
  output logic              clr_we,
  output logic [ADDR_W-1:0] clr_addr
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  clr_state_e        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;

  // State and sweep pointer; reset always (re)starts a sweep from entry 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_CLEAR;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state, pointer advance and clear-write strobe.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    busy     = 1'b0;
    clr_we   = 1'b0;
    clr_addr = ptr_q;
    case (state_q)
      ST_IDLE: begin
        if (clr_start) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        busy   = 1'b1;
        clr_we = 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = ST_IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ptr_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/excess_ram_multiport.sv
// Excess-count store for CLAHE clip-limit redistribution, one entry per tile.
// One write port (overwrite or saturating accumulate), NUM_RD registered read
// ports with one cycle latency, and a built-in clear sweep.
// Build option: define EXCESS_RAM_BYPASS_EN to make a read of the entry being
// written (or cleared) in the same cycle return the new value instead of the
// old one. DATA_W may be at most 32.
module excess_ram_multiport
  import clahe_excess_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  parameter  int NUM_RD = DEF_NUM_RD,
  localparam int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     clr_start,
  output logic                     busy,
  input  logic                     wr_en,
  input  logic                     wr_acc,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  output logic                     wr_drop,
  output logic                     sat_flag,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_valid
);

  localparam logic [ADDR_W:0] DEPTH_X = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              wr_addr_ok;
  logic              user_we;
  logic [DATA_W-1:0] old_val;
  logic [32:0]       sat_res;
  logic [31:0]       sat_hi;
  logic              acc_ovf;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic wr_drop_q, wr_drop_d;
  logic sat_flag_q, sat_flag_d;

  excess_clear_seq #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_clr (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .busy      (busy),
    .clr_we    (clr_we),
    .clr_addr  (clr_addr)
  );

  // Write arbitration: the clear sweep owns the memory while busy, user
  // writes land only when idle and in range; accumulate saturates.
  always_comb begin
    wr_addr_ok = ({1'b0, wr_addr} < DEPTH_X);
    user_we    = wr_en && !busy && wr_addr_ok && !rst;
    old_val    = wr_addr_ok ? mem_q[wr_addr] : '0;
    sat_res    = sat_add(32'(old_val), 32'(wr_data), DATA_W);
    // Upper bits are zero by construction; folding them in keeps every bit
    // of the adder result observed and turns any width slip into a clip.
    sat_hi     = sat_res[31:0] >> DATA_W;
    acc_ovf    = sat_res[32] | (|sat_hi);

    mem_we     = (clr_we && !rst) || user_we;
    mem_waddr  = clr_we ? clr_addr : wr_addr;
    if (clr_we) begin
      mem_wdata = '0;
    end else if (wr_acc) begin
      mem_wdata = sat_res[DATA_W-1:0];
    end else begin
      mem_wdata = wr_data;
    end

    wr_drop_d  = wr_en && !user_we && !rst;
    sat_flag_d = user_we && wr_acc && acc_ovf;
  end

  // Storage array; contents are established by the clear sweep, not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // One-cycle status pulses for dropped writes and clipped accumulates.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_drop_q  <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      wr_drop_q  <= wr_drop_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign wr_drop  = wr_drop_q;
  assign sat_flag = sat_flag_q;

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] raddr;
    logic              raddr_ok;
    logic [DATA_W-1:0] rdata_d;
    logic [DATA_W-1:0] rdata_q;
    logic              rvalid_q;

    // Read mux: out-of-range addresses return zero; optional write bypass.
    always_comb begin
      raddr    = rd_addr[k*ADDR_W +: ADDR_W];
      raddr_ok = ({1'b0, raddr} < DEPTH_X);
      rdata_d  = raddr_ok ? mem_q[raddr] : '0;
`ifdef EXCESS_RAM_BYPASS_EN
      if (mem_we && raddr_ok && (mem_waddr == raddr)) begin
        rdata_d = mem_wdata;
      end
`else
`endif
    end

    // Registered read port; data holds its last value when not enabled.
    always_ff @(posedge clk) begin
      if (rst) begin
        rdata_q  <= '0;
        rvalid_q <= 1'b0;
      end else begin
        rvalid_q <= rd_en[k];
        if (rd_en[k]) begin
          rdata_q <= rdata_d;
        end
      end
    end

    assign rd_data[k*DATA_W +: DATA_W] = rdata_q;
    assign rd_valid[k]                 = rvalid_q;
  end

endmodule

// File: tb/tb_excess_ram_multiport.sv
// Directed bench for excess_ram_multiport at default parameters
// (DATA_W=16, DEPTH=32, NUM_RD=4). Honours EXCESS_RAM_BYPASS_EN for the
// same-cycle read/write case.
module tb_excess_ram_multiport;

  localparam int DW = 16;
  localparam int AW = 5;
  localparam int NR = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           clr_start;
  logic           busy;
  logic           wr_en;
  logic           wr_acc;
  logic [AW-1:0]  wr_addr;
  logic [DW-1:0]  wr_data;
  logic           wr_drop;
  logic           sat_flag;
  logic [NR-1:0]  rd_en;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*DW-1:0] rd_data;
  logic [NR-1:0]  rd_valid;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  excess_ram_multiport dut (
    .clk       (clk),
    .rst       (rst),
    .clr_start (clr_start),
    .busy      (busy),
    .wr_en     (wr_en),
    .wr_acc    (wr_acc),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_drop   (wr_drop),
    .sat_flag  (sat_flag),
    .rd_en     (rd_en),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [NR-1:0] en, input logic [AW-1:0] a0,
                        input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                        input logic [AW-1:0] a3);
    rd_en   = en;
    rd_addr = {a3, a2, a1, a0};
  endtask

  task automatic do_write(input logic acc, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_acc  = acc;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic no_write();
    wr_en   = 1'b0;
    wr_acc  = 1'b0;
    wr_addr = '0;
    wr_data = '0;
  endtask

  function automatic logic [DW-1:0] port_data(input logic [NR*DW-1:0] bus, input int k);
    return bus[k*DW +: DW];
  endfunction

  initial begin
    int cnt;
    logic [DW-1:0] exp_same;

    rst = 1'b1;
    clr_start = 1'b0;
    no_write();
    set_rd('0, 0, 0, 0, 0);

    // Reset state and length of the power-on sweep.
    tick();
    chk("rst_rd_valid", 32'(rd_valid), 32'h0);
    chk("rst_rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
    chk("rst_wr_drop", 32'(wr_drop), 32'h0);
    chk("rst_sat_flag", 32'(sat_flag), 32'h0);
    rst = 1'b0;
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      tick();
    end
    chk("init_busy_cycles", 32'(cnt), 32'd32);

    // Every entry reads zero on all ports after the sweep.
    for (int a = 0; a < 32; a += 4) begin
      set_rd(4'b1111, AW'(a), AW'(a + 1), AW'(a + 2), AW'(a + 3));
      tick();
      chk("init_valid", 32'(rd_valid), 32'hF);
      for (int k = 0; k < NR; k++) chk("init_zero", 32'(port_data(rd_data, k)), 32'h0);
    end

    // Overwrite then read the same entry from all four ports.
    set_rd('0, 0, 0, 0, 0);
    do_write(1'b0, 5'd5, 16'h1234);
    tick();
    chk("ovw_drop", 32'(wr_drop), 32'h0);
    no_write();
    set_rd(4'b1111, 5'd5, 5'd5, 5'd5, 5'd5);
    tick();
    chk("ovw_valid", 32'(rd_valid), 32'hF);
    for (int k = 0; k < NR; k++) chk("ovw_data", 32'(port_data(rd_data, k)), 32'h1234);

    // Disabled ports drop valid but keep their data.
    set_rd('0, 5'd0, 5'd0, 5'd0, 5'd0);
    tick();
    chk("hold_valid", 32'(rd_valid), 32'h0);
    chk("hold_data", 32'(port_data(rd_data, 2)), 32'h1234);

    // Saturating accumulate.
    do_write(1'b0, 5'd7, 16'hFFF0);
    tick();
    do_write(1'b1, 5'd7, 16'h0020);
    tick();
    chk("sat_pulse", 32'(sat_flag), 32'h1);
    no_write();
    set_rd(4'b0001, 5'd7, 0, 0, 0);
    tick();
    chk("sat_pulse_end", 32'(sat_flag), 32'h0);
    chk("sat_value", 32'(port_data(rd_data, 0)), 32'hFFFF);

    // Back-to-back accumulates to one entry.
    set_rd('0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      do_write(1'b1, 5'd2, 16'd10);
      tick();
      chk("acc_no_sat", 32'(sat_flag), 32'h0);
    end
    no_write();
    set_rd(4'b0010, 0, 5'd2, 0, 0);
    tick();
    chk("acc_sum", 32'(port_data(rd_data, 1)), 32'd30);

    // Clear on request: dropped write, ignored restart, entry zeroed.
    set_rd('0, 0, 0, 0, 0);
    do_write(1'b0, 5'd3, 16'h5555);
    tick();
    no_write();
    set_rd(4'b0001, 5'd3, 0, 0, 0);
    tick();
    chk("pre_clr_val", 32'(port_data(rd_data, 0)), 32'h5555);
    set_rd('0, 0, 0, 0, 0);
    clr_start = 1'b1;
    tick();
    clr_start = 1'b0;
    chk("clr_busy", 32'(busy), 32'h1);
    cnt = 0;
    while (busy && cnt < 100) begin
      cnt++;
      if (cnt == 1) begin
        do_write(1'b0, 5'd3, 16'h7777);
        clr_start = 1'b1;
      end else begin
        no_write();
        clr_start = 1'b0;
      end
      tick();
      if (cnt == 1) chk("busy_drop", 32'(wr_drop), 32'h1);
      if (cnt == 2) chk("busy_drop_end", 32'(wr_drop), 32'h0);
    end
    no_write();
    clr_start = 1'b0;
    chk("clr_busy_cycles", 32'(cnt), 32'd32);
    set_rd(4'b1001, 5'd3, 0, 0, 5'd5);
    tick();
    chk("clr_addr3", 32'(port_data(rd_data, 0)), 32'h0);
    chk("clr_addr5", 32'(port_data(rd_data, 3)), 32'h0);

    // Same-cycle write and read of one entry.
`ifdef EXCESS_RAM_BYPASS_EN
    exp_same = 16'hABCD;
`else
    exp_same = 16'h0000;
`endif
    do_write(1'b0, 5'd9, 16'hABCD);
    set_rd(4'b0001, 5'd9, 0, 0, 0);
    tick();
    chk("rw_same_cycle", 32'(port_data(rd_data, 0)), 32'(exp_same));
    no_write();
    tick();
    chk("rw_next_read", 32'(port_data(rd_data, 0)), 32'hABCD);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
